// File: rtl/multicycle_ctrl_v2_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcode classes
// and the datapath select encodings driven onto the control bus.
package multicycle_ctrl_v2_pkg;

    typedef enum logic [4:0] {
        S_BOOT      = 5'd0,
        S_FETCH     = 5'd1,
        S_DECODE    = 5'd2,
        S_MEM_ADDR  = 5'd3,
        S_MEM_READ  = 5'd4,
        S_MEM_WB    = 5'd5,
        S_MEM_WRITE = 5'd6,
        S_R_EXEC    = 5'd7,
        S_R_WB      = 5'd8,
        S_JR        = 5'd9,
        S_BRANCH    = 5'd10,
        S_JUMP      = 5'd11,
        S_I_EXEC    = 5'd12,
        S_I_WB      = 5'd13,
        S_OUT_ADDR  = 5'd14,
        S_OUT_WRITE = 5'd15,
        S_IN_WAIT   = 5'd16,
        S_IN_WB     = 5'd17,
        S_HALT      = 5'd18,
        S_FAULT     = 5'd19
    } state_e;

    localparam logic [2:0] CLS_R      = 3'b000;
    localparam logic [2:0] CLS_MEM    = 3'b001;
    localparam logic [2:0] CLS_BRANCH = 3'b010;
    localparam logic [2:0] CLS_HALT   = 3'b011;
    localparam logic [2:0] CLS_IMM    = 3'b100;
    localparam logic [2:0] CLS_OUT    = 3'b101;
    localparam logic [2:0] CLS_IN     = 3'b110;
    localparam logic [2:0] CLS_JUMP   = 3'b111;

    localparam logic [1:0] PC_SRC_ULA    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    localparam logic [1:0] DATA_SRC_MEM  = 2'b00;
    localparam logic [1:0] DATA_SRC_ULA  = 2'b01;
    localparam logic [1:0] DATA_SRC_IN   = 2'b10;
    localparam logic [1:0] DATA_SRC_LINK = 2'b11;

    localparam logic [1:0] B_SRC_REG    = 2'b00;
    localparam logic [1:0] B_SRC_FOUR   = 2'b01;
    localparam logic [1:0] B_SRC_IMM    = 2'b10;
    localparam logic [1:0] B_SRC_OFFSET = 2'b11;

    localparam logic [1:0] ULA_OP_NONE = 2'b00;
    localparam logic [1:0] ULA_OP_ADD  = 2'b10;
    localparam logic [1:0] ULA_OP_FUNC = 2'b11;

    typedef struct packed {
        logic       pc_cond;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       mem_src;
        logic       mem_write;
        logic       mem_read;
        logic       ir_write;
        logic       reg_src;
        logic       reg_write;
        logic [1:0] data_src;
        logic       a_src;
        logic [1:0] b_src;
        logic [1:0] ula_op;
        logic       display_write;
        logic       halted;
        logic       fault;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_v2_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface multicycle_ctrl_v2_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                memReady;
    logic                pcCond;
    logic                pcWrite;
    logic [1:0]          pcSrc;
    logic                memSrc;
    logic                memWrite;
    logic                memRead;
    logic                irWrite;
    logic                regSrc;
    logic                regWrite;
    logic [1:0]          dataSrc;
    logic                aSrc;
    logic [1:0]          bSrc;
    logic [1:0]          ulaOp;
    logic                displayWrite;
    logic                halted;
    logic                fault;
    logic [CNT_W-1:0]    instrCount;
    logic [4:0]          estadoCU;

    modport master (
        input  opcode, memReady,
        output pcCond, pcWrite, pcSrc, memSrc, memWrite, memRead, irWrite,
               regSrc, regWrite, dataSrc, aSrc, bSrc, ulaOp, displayWrite,
               halted, fault, instrCount, estadoCU
    );

    modport slave (
        output opcode, memReady,
        input  pcCond, pcWrite, pcSrc, memSrc, memWrite, memRead, irWrite,
               regSrc, regWrite, dataSrc, aSrc, bSrc, ulaOp, displayWrite,
               halted, fault, instrCount, estadoCU
    );
endinterface

// File: rtl/enter_sync_edge.sv
// Synchronises the asynchronous enter button and emits one pulse per rising edge;
// a held button therefore yields exactly one pulse.
module enter_sync_edge #(
    parameter int ENTER_SYNC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enter,
    output logic enter_pulse
);
    logic [ENTER_SYNC-1:0] sync_r;
    logic                  edge_r;

    // Synchroniser chain plus previous-value register for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= (sync_r << 1) | ENTER_SYNC'(enter);
            edge_r <= sync_r[ENTER_SYNC-1];
        end
    end

    assign enter_pulse = sync_r[ENTER_SYNC-1] & ~edge_r;
endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle CPU control FSM: fetch/decode/execute/writeback sequencing with
// memory wait-state timeout, HALT/input handshakes and a retired-instruction counter.
module multicycle_ctrl_v2
    import multicycle_ctrl_v2_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ENTER_SYNC  = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enter,
    multicycle_ctrl_v2_if.master bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

    state_e              state_r;
    state_e              state_n_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [CNT_W-1:0]    instr_cnt_r;
    logic [2:0]          op_class_s;
    logic                op0_s;
    logic                enter_pulse_s;
    logic                wait_state_s;
    logic                timeout_s;
    logic                unused_opcode_s;
    ctrl_t               ctrl_s;

    enter_sync_edge #(.ENTER_SYNC(ENTER_SYNC)) u_enter_sync_edge (
        .clk         (clk),
        .reset       (reset),
        .enter       (enter),
        .enter_pulse (enter_pulse_s)
    );

    assign op_class_s      = bus.opcode[OPCODE_W-1 -: 3];
    assign op0_s           = bus.opcode[0];
    assign unused_opcode_s = ^bus.opcode;
    assign wait_state_s    = (state_r == S_FETCH) || (state_r == S_MEM_READ) || (state_r == S_MEM_WRITE);
    // The final waiting cycle is the one whose increment would reach the limit.
    assign timeout_s       = TIMEOUT_EN && !bus.memReady && (wait_cnt_r == WAIT_LIMIT);

    // Next-state selection
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            S_BOOT:      state_n_s = S_FETCH;
            S_FETCH: begin
                if (bus.memReady)   state_n_s = S_DECODE;
                else if (timeout_s) state_n_s = S_FAULT;
                else                state_n_s = S_FETCH;
            end
            S_DECODE: begin
                case (op_class_s)
                    CLS_R:      state_n_s = S_R_EXEC;
                    CLS_MEM:    state_n_s = S_MEM_ADDR;
                    CLS_BRANCH: state_n_s = S_BRANCH;
                    CLS_HALT:   state_n_s = S_HALT;
                    CLS_IMM:    state_n_s = S_I_EXEC;
                    CLS_OUT:    state_n_s = S_OUT_ADDR;
                    CLS_IN:     state_n_s = S_IN_WAIT;
                    CLS_JUMP:   state_n_s = S_JUMP;
                    default:    state_n_s = S_FAULT;
                endcase
            end
            S_MEM_ADDR:  state_n_s = op0_s ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (bus.memReady)   state_n_s = S_MEM_WB;
                else if (timeout_s) state_n_s = S_FAULT;
                else                state_n_s = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (bus.memReady)   state_n_s = S_FETCH;
                else if (timeout_s) state_n_s = S_FAULT;
                else                state_n_s = S_MEM_WRITE;
            end
            S_R_EXEC:    state_n_s = op0_s ? S_JR : S_R_WB;
            S_I_EXEC:    state_n_s = S_I_WB;
            S_OUT_ADDR:  state_n_s = S_OUT_WRITE;
            S_IN_WAIT:   state_n_s = enter_pulse_s ? S_IN_WB : S_IN_WAIT;
            S_HALT:      state_n_s = enter_pulse_s ? S_FETCH : S_HALT;
            S_MEM_WB, S_R_WB, S_JR, S_BRANCH, S_JUMP,
            S_I_WB, S_OUT_WRITE, S_IN_WB: state_n_s = S_FETCH;
            S_FAULT:     state_n_s = S_FAULT;
            default:     state_n_s = S_FAULT;
        endcase
    end

    // Control word decode; only the FETCH load strobes look at memReady
    always_comb begin
        ctrl_s = '0;
        case (state_r)
            S_FETCH: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.b_src    = B_SRC_FOUR;
                ctrl_s.ula_op   = ULA_OP_ADD;
                ctrl_s.pc_src   = PC_SRC_ULA;
                ctrl_s.ir_write = bus.memReady;
                ctrl_s.pc_write = bus.memReady;
            end
            S_DECODE: begin
                ctrl_s.b_src  = B_SRC_OFFSET;
                ctrl_s.ula_op = ULA_OP_ADD;
            end
            S_MEM_ADDR, S_OUT_ADDR: begin
                ctrl_s.a_src  = 1'b1;
                ctrl_s.b_src  = B_SRC_IMM;
                ctrl_s.ula_op = ULA_OP_ADD;
            end
            S_MEM_READ: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.mem_src  = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.data_src  = DATA_SRC_MEM;
            end
            S_MEM_WRITE: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.mem_src   = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_s.a_src  = 1'b1;
                ctrl_s.b_src  = B_SRC_REG;
                ctrl_s.ula_op = ULA_OP_NONE;
            end
            S_R_WB: begin
                ctrl_s.reg_src   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.data_src  = DATA_SRC_ULA;
            end
            S_JR: begin
                ctrl_s.pc_write = 1'b1;
                ctrl_s.pc_src   = PC_SRC_REG;
            end
            S_BRANCH: begin
                ctrl_s.a_src   = 1'b1;
                ctrl_s.ula_op  = ULA_OP_FUNC;
                ctrl_s.pc_cond = 1'b1;
                ctrl_s.pc_src  = PC_SRC_BRANCH;
            end
            S_JUMP: begin
                ctrl_s.pc_write  = 1'b1;
                ctrl_s.pc_src    = PC_SRC_JUMP;
                ctrl_s.reg_src   = 1'b1;
                ctrl_s.data_src  = DATA_SRC_LINK;
                ctrl_s.reg_write = op0_s;
            end
            S_I_EXEC: begin
                ctrl_s.a_src  = 1'b1;
                ctrl_s.b_src  = B_SRC_IMM;
                ctrl_s.ula_op = ULA_OP_FUNC;
            end
            S_I_WB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.data_src  = DATA_SRC_ULA;
            end
            S_OUT_WRITE: ctrl_s.display_write = 1'b1;
            S_IN_WB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.data_src  = DATA_SRC_IN;
            end
            S_HALT:      ctrl_s.halted = 1'b1;
            S_FAULT:     ctrl_s.fault  = 1'b1;
            default:     ctrl_s = '0;
        endcase
    end

    // State, memory wait counter and retired-instruction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_BOOT;
            wait_cnt_r  <= '0;
            instr_cnt_r <= '0;
        end else begin
            state_r <= state_n_s;
            if (state_n_s != state_r) begin
                wait_cnt_r <= '0;
            end else if (wait_state_s) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if ((state_n_s == S_FETCH) && (state_r != S_FETCH) && (state_r != S_BOOT)) begin
                instr_cnt_r <= instr_cnt_r + CNT_W'(1);
            end else begin
                instr_cnt_r <= instr_cnt_r;
            end
        end
    end

    assign bus.pcCond       = ctrl_s.pc_cond;
    assign bus.pcWrite      = ctrl_s.pc_write;
    assign bus.pcSrc        = ctrl_s.pc_src;
    assign bus.memSrc       = ctrl_s.mem_src;
    assign bus.memWrite     = ctrl_s.mem_write;
    assign bus.memRead      = ctrl_s.mem_read;
    assign bus.irWrite      = ctrl_s.ir_write;
    assign bus.regSrc       = ctrl_s.reg_src;
    assign bus.regWrite     = ctrl_s.reg_write;
    assign bus.dataSrc      = ctrl_s.data_src;
    assign bus.aSrc         = ctrl_s.a_src;
    assign bus.bSrc         = ctrl_s.b_src;
    assign bus.ulaOp        = ctrl_s.ula_op;
    assign bus.displayWrite = ctrl_s.display_write;
    assign bus.halted       = ctrl_s.halted;
    assign bus.fault        = ctrl_s.fault;
    assign bus.instrCount   = instr_cnt_r;
    assign bus.estadoCU     = state_r;
endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Bench for multicycle_ctrl_v2: directed table, hand-written corner sequences and
// randomized instructions checked against an instruction-level phase model.
module tb_multicycle_ctrl_v2;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    logic enter;
    int   checks   = 0;
    int   failures = 0;
    int   mdl_cnt  = 0;
    logic [2:0] eh = 3'b000;
    bit   mr_q[$];
    bit   en_q[$];
    bit   rand_mode = 1'b0;

    typedef struct {
        logic [5:0] op;
        int         len;
        int         path[5];
    } vec_t;
    vec_t tbl[9];

    multicycle_ctrl_v2_if #(.OPCODE_W(6), .CNT_W(16)) bus ();

    multicycle_ctrl_v2 #(.OPCODE_W(6), .ENTER_SYNC(2), .MEM_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .enter (enter),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] exp_ctrl(input int st, input logic op0, input logic mr);
        logic pc_cond = 0, pc_write = 0, mem_src = 0, mem_write = 0, mem_read = 0;
        logic ir_write = 0, reg_src = 0, reg_write = 0, a_src = 0, disp = 0, halted = 0, fault = 0;
        logic [1:0] pc_src = 0, data_src = 0, b_src = 0, ula_op = 0;
        case (st)
            1:  begin mem_read = 1; b_src = 2'b01; ula_op = 2'b10; ir_write = mr; pc_write = mr; end
            2:  begin b_src = 2'b11; ula_op = 2'b10; end
            3, 14: begin a_src = 1; b_src = 2'b10; ula_op = 2'b10; end
            4:  begin mem_read = 1; mem_src = 1; end
            5:  reg_write = 1;
            6:  begin mem_write = 1; mem_src = 1; end
            7:  a_src = 1;
            8:  begin reg_src = 1; reg_write = 1; data_src = 2'b01; end
            9:  begin pc_write = 1; pc_src = 2'b11; end
            10: begin a_src = 1; ula_op = 2'b11; pc_cond = 1; pc_src = 2'b01; end
            11: begin pc_write = 1; pc_src = 2'b10; reg_src = 1; data_src = 2'b11; reg_write = op0; end
            12: begin a_src = 1; b_src = 2'b10; ula_op = 2'b11; end
            13: begin reg_write = 1; data_src = 2'b01; end
            15: disp = 1;
            17: begin reg_write = 1; data_src = 2'b10; end
            18: halted = 1;
            19: fault = 1;
            default: ;
        endcase
        return {pc_cond, pc_write, pc_src, mem_src, mem_write, mem_read, ir_write, reg_src,
                reg_write, data_src, a_src, b_src, ula_op, disp, halted, fault};
    endfunction

    function automatic logic [19:0] act_ctrl();
        return {bus.pcCond, bus.pcWrite, bus.pcSrc, bus.memSrc, bus.memWrite, bus.memRead,
                bus.irWrite, bus.regSrc, bus.regWrite, bus.dataSrc, bus.aSrc, bus.bSrc,
                bus.ulaOp, bus.displayWrite, bus.halted, bus.fault};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_now(input int st, input string tag);
        #1;
        chk({tag, ".state"}, 32'(bus.estadoCU), st);
        chk({tag, ".ctrl"}, 32'(act_ctrl()), 32'(exp_ctrl(st, bus.opcode[0], bus.memReady)));
        chk({tag, ".count"}, 32'(bus.instrCount), mdl_cnt);
    endtask

    // Advance to the next falling edge, recording the enter value the rising edge saw.
    task automatic step();
        eh = reset ? {eh[1:0], enter} : 3'b000;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enter = 1'b0;
        mdl_cnt = 0;
        check_now(0, "reset");
        step();
        reset = 1'b1;
        check_now(0, "release");
        step();
    endtask

    function automatic bit next_mr();
        if (mr_q.size() > 0) return mr_q.pop_front();
        if (rand_mode) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    function automatic bit next_en(input bit waiting);
        if (en_q.size() > 0) return en_q.pop_front();
        if (waiting) return ~enter;
        if (rand_mode) return ($urandom_range(0, 4) == 0);
        return 1'b0;
    endfunction

    // Instruction-level model: list the phases the opcode class visits, then walk them,
    // consuming memReady in memory-wait phases and synchronised enter edges in button phases.
    task automatic run_instr(input logic [5:0] op);
        int ph[$];
        int st;
        int waited;
        bit mr;
        bit pulse;
        bus.opcode = op;
        ph.push_back(1);
        ph.push_back(2);
        case (op[5:3])
            3'd0: begin ph.push_back(7); ph.push_back(op[0] ? 9 : 8); end
            3'd1: begin
                ph.push_back(3);
                if (op[0]) ph.push_back(6);
                else begin ph.push_back(4); ph.push_back(5); end
            end
            3'd2: ph.push_back(10);
            3'd3: ph.push_back(18);
            3'd4: begin ph.push_back(12); ph.push_back(13); end
            3'd5: begin ph.push_back(14); ph.push_back(15); end
            3'd6: begin ph.push_back(16); ph.push_back(17); end
            default: ph.push_back(11);
        endcase
        foreach (ph[i]) begin
            st = ph[i];
            waited = 0;
            forever begin
                if (st == 1 || st == 4 || st == 6) mr = next_mr();
                else mr = 1'($urandom_range(0, 1));
                bus.memReady = mr;
                enter = next_en(st == 16 || st == 18);
                check_now(st, $sformatf("op%b", op));
                pulse = eh[1] & ~eh[2];
                step();
                if (st == 1 || st == 4 || st == 6) begin
                    if (mr) break;
                    waited++;
                    if (waited == TO) begin
                        for (int k = 0; k < 3; k++) begin
                            enter = 1'($urandom_range(0, 1));
                            check_now(19, "fault_hold");
                            step();
                        end
                        do_reset();
                        return;
                    end
                end else if (st == 16 || st == 18) begin
                    if (pulse) break;
                    waited++;
                    if (waited == 60) begin
                        chk("enter_wait_bound", 32'(bus.estadoCU), 32'(st + 1));
                        do_reset();
                        return;
                    end
                end else begin
                    break;
                end
            end
        end
        mdl_cnt++;
    endtask

    initial begin
        tbl[0] = '{op: 6'b000000, len: 4, path: '{1, 2, 7, 8, 0}};
        tbl[1] = '{op: 6'b000001, len: 4, path: '{1, 2, 7, 9, 0}};
        tbl[2] = '{op: 6'b001000, len: 5, path: '{1, 2, 3, 4, 5}};
        tbl[3] = '{op: 6'b001001, len: 4, path: '{1, 2, 3, 6, 0}};
        tbl[4] = '{op: 6'b010000, len: 3, path: '{1, 2, 10, 0, 0}};
        tbl[5] = '{op: 6'b100000, len: 4, path: '{1, 2, 12, 13, 0}};
        tbl[6] = '{op: 6'b101000, len: 4, path: '{1, 2, 14, 15, 0}};
        tbl[7] = '{op: 6'b111001, len: 3, path: '{1, 2, 11, 0, 0}};
        tbl[8] = '{op: 6'b111000, len: 3, path: '{1, 2, 11, 0, 0}};

        reset = 1'b0;
        enter = 1'b0;
        bus.opcode = 6'b000000;
        bus.memReady = 1'b0;
        @(negedge clk);
        do_reset();

        // Table-driven: every class with memory always ready
        for (int i = 0; i < 9; i++) begin
            bus.opcode = tbl[i].op;
            for (int k = 0; k < tbl[i].len; k++) begin
                bus.memReady = 1'b1;
                enter = 1'b0;
                check_now(tbl[i].path[k], $sformatf("tbl%0d", i));
                step();
            end
            mdl_cnt++;
        end

        // Load with three wait cycles in MEM_READ
        mr_q = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_instr(6'b001000);
        // Store with memory stuck: timeout to FAULT, cleared only by reset
        mr_q = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run_instr(6'b001001);
        // Button press during R_EXEC is discarded, then an input instruction
        en_q = {1'b0, 1'b0, 1'b1, 1'b0};
        run_instr(6'b000000);
        run_instr(6'b110000);
        // Button held for 20 cycles: one IN_WB only; the next input waits for a fresh press
        en_q.delete();
        repeat (20) en_q.push_back(1'b1);
        run_instr(6'b110000);
        run_instr(6'b110000);
        // HALT held, then resumed by a press
        en_q.delete();
        repeat (12) en_q.push_back(1'b0);
        run_instr(6'b011000);
        run_instr(6'b111001);
        run_instr(6'b111000);

        // Reset asserted while in JUMP clears every output immediately
        bus.opcode = 6'b111001;
        bus.memReady = 1'b1;
        enter = 1'b0;
        check_now(1, "abort");
        step();
        check_now(2, "abort");
        step();
        check_now(11, "abort");
        #2;
        do_reset();

        rand_mode = 1'b1;
        repeat (150) run_instr(6'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_v2.md
Name: multicycle_ctrl_v2

Overview:
Multicycle control FSM that sequences fetch, decode, execute and writeback for the CPU datapath, driving the PC, memory, IR, register file, ULA and display enables. It generalises the first-generation controller in several ways:
- parametrised opcode width;
- memory wait states with a timeout-to-fault;
- an internally synchronised `enter` handshake;
- a HALT class (opcode class 3'b011);
- a retired-instruction counter.

Parameters:
- OPCODE_W, 6: opcode width, must be >= 3. The class field is opcode[OPCODE_W-1 -: 3].
- ENTER_SYNC, 2: number of synchroniser flops on `enter`, must be >= 1.
- MEM_TIMEOUT, 16: maximum cycles to wait for memReady in any wait state. 0 disables the timeout.
- CNT_W, 16: width of instrCount.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  opcode field from IR.
- memReady  in  1  memory completes a read or write this cycle.
- enter  in  1  asynchronous user button (input instruction and HALT resume).
- pcCond, pcWrite  out  1 each  PC conditional / unconditional write.
- pcSrc  out  2  PC source select.
- memSrc, memWrite, memRead  out  1 each  memory address select and strobes.
- irWrite  out  1  IR load.
- regSrc, regWrite  out  1 each  destination-register select and write enable.
- dataSrc  out  2  register write-data select.
- aSrc  out  1  ULA A select.
- bSrc, ulaOp  out  2 each  ULA B select and operation.
- displayWrite  out  1  display latch.
- halted  out  1  high while in HALT.
- fault  out  1  high while in FAULT.
- instrCount  out  CNT_W  retired-instruction count.
- estadoCU  out  5  current state code.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to BOOT; all control outputs, halted, fault and instrCount are 0.
  - The enter synchroniser and edge detector clear.
  - BOOT moves to FETCH on the first clock edge after release.
- State codes:
  - 0 BOOT, 1 FETCH, 2 DECODE, 3 MEM_ADDR, 4 MEM_READ
  - 5 MEM_WB, 6 MEM_WRITE, 7 R_EXEC, 8 R_WB, 9 JR
  - 10 BRANCH, 11 JUMP, 12 I_EXEC, 13 I_WB, 14 OUT_ADDR
  - 15 OUT_WRITE, 16 IN_WAIT, 17 IN_WB, 18 HALT, 19 FAULT
  - Unused codes go to FAULT.
- Control outputs: all 0 unless listed below. Moore decode of state, except the memReady-qualified terms in FETCH.
  - FETCH: memRead=1, bSrc=01, ulaOp=10, irWrite=pcWrite=memReady.
  - DECODE: bSrc=11, ulaOp=10.
  - MEM_ADDR and OUT_ADDR: aSrc=1, bSrc=10, ulaOp=10.
  - MEM_READ: memRead=1, memSrc=1.
  - MEM_WB: regWrite=1.
  - MEM_WRITE: memWrite=1, memSrc=1.
  - R_EXEC: aSrc=1.
  - R_WB: regSrc=1, regWrite=1, dataSrc=01.
  - JR: pcWrite=1, pcSrc=11.
  - BRANCH: aSrc=1, ulaOp=11, pcCond=1, pcSrc=01.
  - JUMP: pcWrite=1, pcSrc=10, regSrc=1, dataSrc=11, regWrite=opcode[0].
  - I_EXEC: aSrc=1, bSrc=10, ulaOp=11.
  - I_WB: regWrite=1, dataSrc=01.
  - OUT_WRITE: displayWrite=1.
  - IN_WB: regWrite=1, dataSrc=10.
  - HALT: halted=1.
  - FAULT: fault=1.
- Transitions:
  - FETCH -> DECODE when memReady, else stay.
  - DECODE by class: 000 R_EXEC, 001 MEM_ADDR, 010 BRANCH, 011 HALT, 100 I_EXEC, 101 OUT_ADDR, 110 IN_WAIT, 111 JUMP.
  - MEM_ADDR -> MEM_WRITE if opcode[0], else MEM_READ.
  - MEM_READ -> MEM_WB on memReady. MEM_WRITE -> FETCH on memReady.
  - R_EXEC -> JR if opcode[0], else R_WB.
  - I_EXEC -> I_WB. OUT_ADDR -> OUT_WRITE.
  - IN_WAIT -> IN_WB on enterPulse, else stay.
  - HALT -> FETCH on enterPulse, else stay.
  - MEM_WB, R_WB, JR, BRANCH, JUMP, I_WB, OUT_WRITE and IN_WB -> FETCH.
  - FAULT is held until reset.
- enterPulse:
  - enter passes through ENTER_SYNC flops plus an edge register.
  - The pulse is one cycle on each synchronised rising edge.
  - A held button produces exactly one pulse.
  - A pulse outside IN_WAIT/HALT is discarded, not queued.
- Timeout:
  - The wait counter clears on entry to FETCH, MEM_READ and MEM_WRITE, and increments each cycle there without memReady.
  - If it reaches MEM_TIMEOUT with memReady=0, the next state is FAULT.
  - memReady in the same cycle the count reaches the limit wins (normal transition).
- instrCount increments by 1 on every transition into FETCH from any state other than BOOT, and wraps modulo 2^CNT_W.
- Reset mid-instruction aborts immediately; no strobe is asserted after reset falls.

Decomposition:
- ctrl_pkg holds:
  - state code constants;
  - opcode class constants;
  - pcSrc, dataSrc, bSrc and ulaOp encodings.
- One sub-module, enter_sync_edge (parameter ENTER_SYNC), implements the synchroniser and rising-edge pulse.

Test Plan:
- R-type add (opcode 000000), memReady=1 -> estadoCU 1,2,7,8,1; regWrite=1, dataSrc=01 in state 8; instrCount 0->1.
- Load (001000) with memReady low for 3 cycles in MEM_READ -> state 4 held 3 cycles, memRead=memSrc=1 throughout, then 5 then 1.
- Store (001001) with MEM_TIMEOUT=4 and memReady stuck 0 -> FAULT (19) after 4 cycles in state 6, fault=1; only reset=0 clears it to BOOT.
- Input (110000): enter held high for 20 cycles -> exactly one IN_WB (17) with regWrite=1, dataSrc=10; enter pulsed in state 7 of a prior instruction has no effect.
- HALT (011000) -> halted=1 and state 18 held indefinitely; an enter pulse gives FETCH, and instrCount increments once.
- JAL (111001) -> state 11 with pcWrite=1, pcSrc=10, regWrite=1; J (111000) -> regWrite=0. Reset asserted in state 11 -> all outputs 0 asynchronously.
